wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port between two sources: the ALU
//  writeback path (writebackEnable/aluMuxout from the ALU output mux) and
//  load-data returns from the memory stage.
//  Loads have priority. ALU writes that lose the port are queued in order in
//  a small FIFO. The FIFO drains whenever the port is free.
//  A run-length limiter stops back-to-back loads from starving the queue.
// PARAMETERS
//  DEPTH         4   ALU pending-FIFO entries (power of two, >=2)
//  MAX_LOAD_RUN  3   max consecutive load grants while FIFO non-empty
//  CW            3   width of pendingCount = clog2(DEPTH)+1
// PORTS
//  clk           in   1   system clock, rising edge
//  nReset        in   1   synchronous reset, active-low
//  aluWbValid    in   1   ALU write request (writebackEnable)
//  aluWbAddr     in   4   ALU destination register
//  aluWbData     in   32  ALU write data (aluMuxout)
//  loadValid     in   1   load-return write request
//  loadAddr      in   4   load destination register
//  loadData      in   32  load write data
//  loadReady     out  1   load accepted this cycle when loadValid&loadReady
//  aluStall      out  1   FIFO full; upstream holds and re-presents ALU write
//  rfWriteEn     out  1   register-file write enable (registered)
//  rfWriteAddr   out  4   register-file write address (registered)
//  rfWriteData   out  32  register-file write data (registered)
//  pendingCount  out  CW  FIFO occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset (nReset=0 at clk edge)
//   - rfWriteEn=0, rfWriteAddr=0, rfWriteData=0, pendingCount=0, runCnt=0.
//   - FIFO pointers clear; queued writes are discarded, including mid-drain.
//   - While nReset=0: loadReady=0 and aluStall=1.
//  Acceptance
//   - ALU write accepted iff aluWbValid & !aluStall.
//   - Load accepted iff loadValid & loadReady.
//  Grant priority, one per cycle
//   1. accepted load
//   2. FIFO head
//   3. accepted ALU write, direct; allowed only when FIFO is empty
//  An accepted ALU write that is not granted is enqueued at the tail.
//  Enqueue and dequeue in the same cycle are legal; count is unchanged.
//  The granted source is written to rfWrite* at the next clk edge
//  (latency 1). rfWriteEn=0 when nothing is granted.
//  aluStall = (pendingCount==DEPTH), combinational.
//   - Stays 1 even when a dequeue occurs in the same cycle; no full-bypass.
//  Starvation limiter
//   - runCnt increments on each load grant while FIFO is non-empty.
//   - runCnt clears on any non-load grant or when FIFO is empty.
//   - loadReady = !(pendingCount!=0 && runCnt==MAX_LOAD_RUN).
//   - The FIFO head is therefore granted within MAX_LOAD_RUN+1 cycles.
//  Ordering
//   - ALU writes reach the register file in acceptance order.
//   - No reordering across sources. The hazard unit guarantees no load and
//     ALU write to the same register are in flight together.
//  Boundaries
//   - Full FIFO + loadValid: load granted; FIFO unchanged; aluStall stays 1.
//   - Empty FIFO + both valid: load granted; ALU write enqueued (count=1).
//   - FIFO pointers wrap modulo DEPTH.
// CONFIGURATION
//  WB_BYPASS_EN defined
//   - Adds inputs  byAddr[3:0].
//   - Adds outputs byHit[1], byData[31:0].
//   - byHit=1 when byAddr matches any valid FIFO entry (combinational).
//     byData is the youngest matching entry. The decode stage uses this to
//     read values not yet in the register file.
//  WB_BYPASS_EN undefined
//   - Ports are absent.
//   - Decode must interlock while pendingCount!=0.
// TESTING
//  1. Reset, then aluWbValid=1 addr=5 data=0x1234 for one cycle.
//     -> next cycle rfWriteEn=1, rfWriteAddr=5, rfWriteData=0x1234;
//        pendingCount=0.
//  2. Same cycle: load (r2, 0xAAAA) and ALU (r3, 0xBBBB).
//     -> r2 written at T+1; r3 written at T+2; pendingCount 1 then 0.
//  3. Continuous loadValid with 4 ALU writes queued (DEPTH=4).
//     -> aluStall=1; loadReady drops every 4th cycle; queue drains in order.
//  4. FIFO holds 3 entries, then nReset=0 for one cycle.
//     -> rfWriteEn=0, pendingCount=0, loadReady=0 during reset; no queued
//        write appears afterwards.
//  5. WB_BYPASS_EN: FIFO holds r7=0x11 then r7=0x22, byAddr=7.
//     -> byHit=1, byData=0x22; byAddr=8 -> byHit=0.
//  6. Enqueue and dequeue in the same cycle for 8 cycles.
//     -> pendingCount constant; pointer wrap preserves data order.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: loads win, losing ALU writes queue in a DEPTH-entry FIFO, 1-cycle registered write.
// Optional WB_BYPASS_EN adds a combinational lookup (byAddr/byHit/byData) into the pending ALU writes.
module wb_port_arbiter #(
  parameter int DEPTH        = 4,
  parameter int MAX_LOAD_RUN = 3,
  parameter int CW           = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          nReset,
  input  logic          aluWbValid,
  input  logic [3:0]    aluWbAddr,
  input  logic [31:0]   aluWbData,
  input  logic          loadValid,
  input  logic [3:0]    loadAddr,
  input  logic [31:0]   loadData,
  output logic          loadReady,
  output logic          aluStall,
  output logic          rfWriteEn,
  output logic [3:0]    rfWriteAddr,
  output logic [31:0]   rfWriteData,
`ifdef WB_BYPASS_EN
  input  logic [3:0]    byAddr,
  output logic          byHit,
  output logic [31:0]   byData,
`endif
  output logic [CW-1:0] pendingCount
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW = $clog2(MAX_LOAD_RUN + 1);

  logic [3:0]    fifo_addr [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [RW-1:0] run_cnt;

  logic fifo_empty;
  logic load_acc;
  logic alu_acc;
  logic grant_load;
  logic grant_fifo;
  logic grant_alu;
  logic enq;
  logic deq;

  assign fifo_empty   = (count == '0);
  assign pendingCount = count;

  // Full stall holds even when the head drains this cycle: no full-bypass path.
  assign aluStall  = !nReset || (count == CW'(DEPTH));
  assign loadReady = nReset && !(!fifo_empty && (run_cnt == RW'(MAX_LOAD_RUN)));

  assign load_acc   = loadValid && loadReady;
  assign alu_acc    = aluWbValid && !aluStall;
  assign grant_load = load_acc;
  assign grant_fifo = !load_acc && !fifo_empty;
  assign grant_alu  = !load_acc && fifo_empty && alu_acc;
  assign enq        = alu_acc && !grant_alu;
  assign deq        = grant_fifo;

  always_ff @(posedge clk) begin
    if (!nReset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      run_cnt     <= '0;
      rfWriteEn   <= 1'b0;
      rfWriteAddr <= '0;
      rfWriteData <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(enq) - CW'(deq);

      if (fifo_empty || !grant_load) run_cnt <= '0;
      else                           run_cnt <= run_cnt + RW'(1);

      rfWriteEn <= grant_load || grant_fifo || grant_alu;
      if (grant_load) begin
        rfWriteAddr <= loadAddr;
        rfWriteData <= loadData;
      end else if (grant_fifo) begin
        rfWriteAddr <= fifo_addr[rd_ptr];
        rfWriteData <= fifo_data[rd_ptr];
      end else if (grant_alu) begin
        rfWriteAddr <= aluWbAddr;
        rfWriteData <= aluWbData;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_addr[wr_ptr] <= aluWbAddr;
      fifo_data[wr_ptr] <= aluWbData;
    end
  end

`ifdef WB_BYPASS_EN
  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    byHit  = 1'b0;
    byData = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count) && (fifo_addr[rd_ptr + PW'(i)] == byAddr)) begin
        byHit  = 1'b1;
        byData = fifo_data[rd_ptr + PW'(i)];
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: queue-level reference model predicts writes, a monitor checks them.
module tb_wb_port_arbiter;

  localparam int DEPTH = 4;
  localparam int MAXR  = 3;
  localparam int CW    = 3;

  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic        aluWbValid = 1'b0;
  logic [3:0]  aluWbAddr = '0;
  logic [31:0] aluWbData = '0;
  logic        loadValid = 1'b0;
  logic [3:0]  loadAddr = '0;
  logic [31:0] loadData = '0;
  logic        loadReady;
  logic        aluStall;
  logic        rfWriteEn;
  logic [3:0]  rfWriteAddr;
  logic [31:0] rfWriteData;
  logic [CW-1:0] pendingCount;
`ifdef WB_BYPASS_EN
  logic [3:0]  byAddr = '0;
  logic        byHit;
  logic [31:0] byData;
`endif

  always #5 clk = ~clk;

  wb_port_arbiter #(.DEPTH(DEPTH), .MAX_LOAD_RUN(MAXR), .CW(CW)) dut (
    .clk(clk), .nReset(nReset),
    .aluWbValid(aluWbValid), .aluWbAddr(aluWbAddr), .aluWbData(aluWbData),
    .loadValid(loadValid), .loadAddr(loadAddr), .loadData(loadData),
    .loadReady(loadReady), .aluStall(aluStall),
    .rfWriteEn(rfWriteEn), .rfWriteAddr(rfWriteAddr), .rfWriteData(rfWriteData),
`ifdef WB_BYPASS_EN
    .byAddr(byAddr), .byHit(byHit), .byData(byData),
`endif
    .pendingCount(pendingCount)
  );

  typedef struct { int cyc; logic [3:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [3:0] addr; logic [31:0] data; } ent_t;

  wr_t  exp_q[$];
  ent_t pend[$];
  wr_t  mon_e;
  int   run = 0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every observed register-file write must match the oldest prediction, in the predicted cycle.
  always @(negedge clk) begin
    if (rfWriteEn === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(rfWriteEn), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_cycle", cyc, mon_e.cyc);
        chk("wr_addr", 32'(rfWriteAddr), 32'(mon_e.addr));
        chk("wr_data", rfWriteData, mon_e.data);
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      chk("missing_write", 32'(rfWriteEn), 32'd1);
      void'(exp_q.pop_front());
    end
  end

  // One cycle: drive inputs, check combinational outputs and advance the reference model.
  task automatic step(input logic rst, input logic av, input logic [3:0] aa, input logic [31:0] ad,
                      input logic lv, input logic [3:0] la, input logic [31:0] ldd);
    logic lrdy, stall, ld, al, nonempty;
    wr_t  w;
    ent_t e;
`ifdef WB_BYPASS_EN
    logic        hit;
    logic [31:0] bd;
    byAddr = 4'($urandom_range(0, 15));
`endif
    nReset = rst; aluWbValid = av; aluWbAddr = aa; aluWbData = ad;
    loadValid = lv; loadAddr = la; loadData = ldd;
    @(negedge clk);
    lrdy  = rst && !(pend.size() != 0 && run == MAXR);
    stall = !rst || (pend.size() == DEPTH);
    chk("pendingCount", 32'(pendingCount), pend.size());
    chk("loadReady", 32'(loadReady), 32'(lrdy));
    chk("aluStall", 32'(aluStall), 32'(stall));
`ifdef WB_BYPASS_EN
    hit = 1'b0; bd = '0;
    foreach (pend[i]) if (pend[i].addr == byAddr) begin hit = 1'b1; bd = pend[i].data; end
    chk("byHit", 32'(byHit), 32'(hit));
    if (hit) chk("byData", byData, bd);
`endif
    if (!rst) begin
      pend.delete();
      run = 0;
    end else begin
      ld = lv && lrdy;
      al = av && !stall;
      nonempty = (pend.size() != 0);
      w.cyc = cyc + 1;
      if (ld) begin
        w.addr = la; w.data = ldd; exp_q.push_back(w);
      end else if (nonempty) begin
        e = pend.pop_front();
        w.addr = e.addr; w.data = e.data; exp_q.push_back(w);
      end else if (al) begin
        w.addr = aa; w.data = ad; exp_q.push_back(w);
        al = 1'b0;
      end
      if (al) begin
        e.addr = aa; e.data = ad; pend.push_back(e);
      end
      run = (nonempty && ld) ? run + 1 : 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic both(input logic av, input logic lv);
    step(1'b1, av, 4'($urandom()), $urandom(), lv, 4'($urandom()), $urandom());
  endtask

  initial begin
    repeat (2) step(1'b0, 1'b1, 4'd1, 32'd1, 1'b1, 4'd2, 32'd2);
    chk("rst_wr_en", 32'(rfWriteEn), 32'd0);
    chk("rst_wr_addr", 32'(rfWriteAddr), 32'd0);
    chk("rst_wr_data", rfWriteData, 32'd0);

    // Single direct ALU write, then a simultaneous load + ALU write.
    step(1'b1, 1'b1, 4'd5, 32'h1234, 1'b0, 4'd0, 32'd0);
    idle();
    step(1'b1, 1'b1, 4'd3, 32'hBBBB, 1'b1, 4'd2, 32'hAAAA);
    repeat (2) idle();

    // Continuous loads fill the FIFO; the limiter must still drain it.
    repeat (20) both(1'b1, 1'b1);
    repeat (16) both(1'b0, 1'b1);
    repeat (DEPTH + 2) idle();

    // Three queued writes discarded by a one-cycle reset.
    repeat (3) both(1'b1, 1'b1);
    step(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    chk("rst_mid_count", 32'(pendingCount), 32'd0);
    repeat (4) idle();

    // Simultaneous enqueue/dequeue across pointer wrap.
    repeat (2) both(1'b1, 1'b1);
    repeat (8) both(1'b1, 1'b0);
    repeat (DEPTH + 2) idle();

    // Randomized traffic with occasional resets.
    repeat (800) begin
      step(1'b1 && ($urandom_range(0, 99) != 0), ($urandom_range(0, 99) < 60),
           4'($urandom()), $urandom(), ($urandom_range(0, 99) < 70), 4'($urandom()), $urandom());
    end

    // Bounded drain, then the scoreboard must be empty.
    for (int i = 0; i < 2 * DEPTH + 4 && (pend.size() != 0 || exp_q.size() != 0); i++) idle();
    idle();
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
